// File: rtl/fd_instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {pc, instr} with flush.
// Optional same-cycle empty-queue bypass is enabled by defining FDQ_BYPASS_EN.
module fd_instr_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             f_valid,
   input  logic [PC_W-1:0]  f_pc,
   input  logic [XLEN-1:0]  f_instr,
   output logic             f_ready,
   output logic             d_valid,
   output logic [PC_W-1:0]  d_pc,
   output logic [XLEN-1:0]  d_instr,
   input  logic             d_ready,
   input  logic             br_en,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [PC_W-1:0]  r_pc_mem    [DEPTH];
   logic [XLEN-1:0]  r_instr_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

`ifdef FDQ_BYPASS_EN
   assign w_bypass = w_empty & f_valid & ~br_en;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed entry taken by decode never enters storage.
   assign w_push = f_valid & ~w_full & ~br_en & ~(w_bypass & d_ready);
   assign w_pop  = ~w_empty & d_ready & ~br_en;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (br_en) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr[AW-1:0]]    <= f_pc;
         r_instr_mem[r_wr_ptr[AW-1:0]] <= f_instr;
      end
   end

   always_comb begin
      f_ready = ~w_full;
      d_valid = ~w_empty | w_bypass;
      d_pc    = '0;
      d_instr = '0;
      count   = r_count;
      full    = w_full;
      empty   = w_empty;
      if (w_bypass) begin
         d_pc    = f_pc;
         d_instr = f_instr;
      end else if (!w_empty) begin
         d_pc    = r_pc_mem[r_rd_ptr[AW-1:0]];
         d_instr = r_instr_mem[r_rd_ptr[AW-1:0]];
      end
   end

endmodule
